vme_bus_master_seq: RTL and testbench

- Synthesizable VME master sequencer sitting directly upstream of the OTMB top-level VME slave port.
- Drives vme_a, vme_am, _vme_cmd, _vme_geo and the vme_d write data; monitors vme_reply.
- Converts a simple valid/ready command stream (read/write, A24 address, D16 data) into a full VME A24/D16 slave cycle with DTACK handshake and timeout.
- Used in bench harnesses and on the loopback test fixture to exercise VME register, BPI and flash-control paths.

---
 rtl/vme_seq_pkg.sv | 54 +++++
 rtl/vme_sync2.sv | 23 ++
 rtl/vme_bus_master_seq.sv | 214 +++++++++++++++++++++
 tb/tb_vme_bus_master_seq.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vme_seq_pkg.sv
// Shared types and constants for the VME A24/D16 master sequencer.
package vme_seq_pkg;

  localparam int unsigned ADR_W  = 23;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned AM_W   = 6;
  localparam int unsigned CMD_W  = 11;
  localparam int unsigned GEO_W  = 7;
  localparam int unsigned LAT_W  = 8;
  localparam int unsigned TMO_W  = 8;
  localparam int unsigned PH_W   = 4;
  localparam int unsigned RPL_W  = 7;

  // Bit positions inside the active-low _vme_cmd bundle
  localparam int unsigned CMD_AS    = 0;
  localparam int unsigned CMD_DS0   = 1;
  localparam int unsigned CMD_DS1   = 2;
  localparam int unsigned CMD_LWORD = 3;
  localparam int unsigned CMD_WRITE = 4;
  localparam int unsigned CMD_IACK  = 5;

  localparam logic [AM_W-1:0]  AM_IDLE  = 6'h3F;
  localparam logic [CMD_W-1:0] CMD_IDLE = 11'h7FF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_AS_ON,
    ST_DS_ON,
    ST_WAIT_ACK,
    ST_RELEASE,
    ST_RESP
  } state_t;

  typedef struct packed {
    logic              write;
    logic [ADR_W-1:0]  adr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  typedef struct packed {
    logic [ADR_W-1:0]  a;
    logic [AM_W-1:0]   am;
    logic [CMD_W-1:0]  cmd;
    logic [DATA_W-1:0] d_out;
    logic              d_oe;
  } bus_t;

  // Odd-parity geographic address, active low, bit 0 always released
  function automatic logic [GEO_W-1:0] geo_code(input logic [4:0] slot5);
    return ~{(^slot5) ^ 1'b1, slot5, 1'b0};
  endfunction

endpackage

// File: rtl/vme_sync2.sv
// Two-flop synchronizer with asynchronous active-low reset.
module vme_sync2 #(
  parameter int unsigned W = 2
) (
  input  logic         clock,
  input  logic         _reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clock or negedge _reset) begin
    if (!_reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/vme_bus_master_seq.sv
// VME A24/D16 master sequencer: valid/ready command in, DTACK-handshaked bus cycle out.
// Optional VME_LAT_CNT_EN adds rsp_lat (clocks from _DS0 assertion to synced DTACK).
module vme_bus_master_seq
  import vme_seq_pkg::*;
#(
  parameter logic [6:0]      SLOT        = 7'd10,
  parameter logic [AM_W-1:0] AM_CODE     = 6'h39,
  parameter int unsigned     SETUP_CYC   = 2,
  parameter int unsigned     STROBE_CYC  = 1,
  parameter int unsigned     TIMEOUT_CYC = 255
) (
  input  logic              clock,
  input  logic              _reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADR_W-1:0]  cmd_adr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_timeout,
  output logic [ADR_W-1:0]  vme_a,
  output logic [AM_W-1:0]   vme_am,
  output logic [CMD_W-1:0]  _vme_cmd,
  output logic [GEO_W-1:0]  _vme_geo,
  output logic [DATA_W-1:0] vme_d_out,
  output logic              vme_d_oe,
  input  logic [DATA_W-1:0] vme_d_in,
  input  logic [RPL_W-1:0]  vme_reply
`ifdef VME_LAT_CNT_EN
  ,
  output logic [LAT_W-1:0]  rsp_lat
`endif
);

  localparam logic [PH_W-1:0]  SETUP_LAST  = PH_W'(SETUP_CYC - 1);
  localparam logic [PH_W-1:0]  STROBE_LAST = PH_W'(STROBE_CYC - 1);
  localparam logic [TMO_W-1:0] TMO_LAST    = TMO_W'(TIMEOUT_CYC - 1);

  state_t            state_q, state_d;
  logic [PH_W-1:0]   ph_q, ph_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  bus_t              bus_q, bus_d;
  logic              cmd_ready_d;
  logic              rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_d;
  logic              rsp_timeout_d;

  cmd_t              cmd_in;
  logic [1:0]        reply_s;
  logic              ack_s;
  logic              is_write;
  logic              unused_reply;

  assign cmd_in       = '{write: cmd_write, adr: cmd_adr, wdata: cmd_wdata};
  assign is_write     = ~bus_q.cmd[CMD_WRITE];
  assign unused_reply = ^vme_reply[RPL_W-1:2];

  vme_sync2 #(.W(2)) u_sync (
    .clock  (clock),
    ._reset (_reset),
    .d      (vme_reply[1:0]),
    .q      (reply_s)
  );

  // DTACK counts only while the slave also enables its driver
  assign ack_s = reply_s[1] & reply_s[0];

  always_ff @(posedge clock or negedge _reset) begin
    if (!_reset) begin
      state_q     <= ST_IDLE;
      ph_q        <= '0;
      tmo_q       <= '0;
      bus_q       <= '{a: '0, am: AM_IDLE, cmd: CMD_IDLE, d_out: '0, d_oe: 1'b0};
      cmd_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_timeout <= 1'b0;
    end else begin
      state_q     <= state_d;
      ph_q        <= ph_d;
      tmo_q       <= tmo_d;
      bus_q       <= bus_d;
      cmd_ready   <= cmd_ready_d;
      rsp_valid   <= rsp_valid_d;
      rsp_rdata   <= rsp_rdata_d;
      rsp_timeout <= rsp_timeout_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    ph_d          = ph_q;
    tmo_d         = tmo_q;
    bus_d         = bus_q;
    cmd_ready_d   = cmd_ready;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = rsp_rdata;
    rsp_timeout_d = rsp_timeout;

    unique case (state_q)
      ST_IDLE: begin
        cmd_ready_d = 1'b1;
        if (cmd_valid && cmd_ready) begin
          state_d                = ST_SETUP;
          ph_d                   = '0;
          cmd_ready_d            = 1'b0;
          bus_d.a                = cmd_in.adr;
          bus_d.am               = AM_CODE;
          bus_d.cmd              = CMD_IDLE;
          bus_d.cmd[CMD_WRITE]   = ~cmd_in.write;
          bus_d.d_oe             = cmd_in.write;
          bus_d.d_out            = cmd_in.write ? cmd_in.wdata : '0;
          rsp_rdata_d            = '0;
          rsp_timeout_d          = 1'b0;
        end
      end

      ST_SETUP: begin
        if (ph_q == SETUP_LAST) begin
          state_d           = ST_AS_ON;
          ph_d              = '0;
          bus_d.cmd[CMD_AS] = 1'b0;
        end else begin
          ph_d = ph_q + PH_W'(1);
        end
      end

      ST_AS_ON: begin
        if (ph_q == STROBE_LAST) begin
          state_d            = ST_DS_ON;
          ph_d               = '0;
          bus_d.cmd[CMD_DS0] = 1'b0;
          bus_d.cmd[CMD_DS1] = 1'b0;
        end else begin
          ph_d = ph_q + PH_W'(1);
        end
      end

      ST_DS_ON: begin
        state_d = ST_WAIT_ACK;
        tmo_d   = '0;
      end

      // Ack is tested before the terminal count so a late DTACK still wins
      ST_WAIT_ACK: begin
        if (ack_s || (tmo_q == TMO_LAST)) begin
          state_d            = ST_RELEASE;
          tmo_d              = '0;
          bus_d.cmd[CMD_AS]  = 1'b1;
          bus_d.cmd[CMD_DS0] = 1'b1;
          bus_d.cmd[CMD_DS1] = 1'b1;
          bus_d.d_oe         = 1'b0;
          bus_d.d_out        = '0;
          rsp_timeout_d      = ~ack_s;
          rsp_rdata_d        = (ack_s && !is_write) ? vme_d_in : '0;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end

      ST_RELEASE: begin
        if (!ack_s || (tmo_q == TMO_LAST)) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          bus_d.am    = AM_IDLE;
          bus_d.cmd   = CMD_IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end

      ST_RESP: begin
        state_d     = ST_IDLE;
        cmd_ready_d = 1'b1;
      end

      default: begin
        state_d     = ST_IDLE;
        cmd_ready_d = 1'b1;
        bus_d       = '{a: '0, am: AM_IDLE, cmd: CMD_IDLE, d_out: '0, d_oe: 1'b0};
      end
    endcase
  end

  assign vme_a     = bus_q.a;
  assign vme_am    = bus_q.am;
  assign _vme_cmd  = bus_q.cmd;
  assign vme_d_out = bus_q.d_out;
  assign vme_d_oe  = bus_q.d_oe;
  assign _vme_geo  = geo_code(SLOT[4:0]);

`ifdef VME_LAT_CNT_EN
  logic [LAT_W-1:0] lat_q;

  // Free-running saturating count restarted on the _DS0 edge
  always_ff @(posedge clock or negedge _reset) begin
    if (!_reset) begin
      lat_q   <= '0;
      rsp_lat <= '0;
    end else begin
      if (state_q == ST_AS_ON && state_d == ST_DS_ON) begin
        lat_q <= '0;
      end else if (lat_q != '1) begin
        lat_q <= lat_q + LAT_W'(1);
      end
      if (state_q == ST_WAIT_ACK && state_d == ST_RELEASE) begin
        rsp_lat <= ack_s ? lat_q : '0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_vme_bus_master_seq.sv
// Randomized bench for vme_bus_master_seq with a transaction-level timing/data model.
module tb_vme_bus_master_seq;

  localparam int SETUP    = 2;
  localparam int STROBE   = 1;
  localparam int TIMEOUT  = 255;
  localparam int SYNC_DLY = 2;
  localparam logic [5:0]  AM   = 6'h39;
  localparam logic [6:0]  GEO  = 7'h2B;

  logic        clock;
  logic        _reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [22:0] cmd_adr;
  logic [15:0] cmd_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_timeout;
  logic [22:0] vme_a;
  logic [5:0]  vme_am;
  logic [10:0] _vme_cmd;
  logic [6:0]  _vme_geo;
  logic [15:0] vme_d_out;
  logic        vme_d_oe;
  logic [15:0] vme_d_in;
  logic [6:0]  vme_reply;
`ifdef VME_LAT_CNT_EN
  logic [7:0]  rsp_lat;
`endif

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  vme_bus_master_seq dut (
    .clock       (clock),
    ._reset      (_reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_adr     (cmd_adr),
    .cmd_wdata   (cmd_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_timeout (rsp_timeout),
    .vme_a       (vme_a),
    .vme_am      (vme_am),
    ._vme_cmd    (_vme_cmd),
    ._vme_geo    (_vme_geo),
    .vme_d_out   (vme_d_out),
    .vme_d_oe    (vme_d_oe),
    .vme_d_in    (vme_d_in),
    .vme_reply   (vme_reply)
`ifdef VME_LAT_CNT_EN
    ,
    .rsp_lat     (rsp_lat)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Slave acking dly clocks after it sees _DS0 low: sync adds SYNC_DLY, detect adds 1.
  function automatic void model(input bit wr, input int dly, input logic [15:0] rd,
                                output bit ack, output logic [15:0] rdata,
                                output int rsp_cyc, output int rel_cyc, output int lat);
    ack = (dly >= 0) && (dly + SYNC_DLY <= TIMEOUT);
    rdata = (ack && !wr) ? rd : 16'h0;
    if (ack) begin
      rel_cyc = dly + SYNC_DLY + 1;
      rsp_cyc = SETUP + STROBE + rel_cyc + SYNC_DLY + 1;
      lat     = dly + SYNC_DLY;
    end else begin
      rel_cyc = TIMEOUT + 1;
      rsp_cyc = SETUP + STROBE + TIMEOUT + 2;
      lat     = 0;
    end
  endfunction

  task automatic wait_ready();
    int guard = 0;
    while (cmd_ready !== 1'b1 && guard < 50) begin
      @(posedge clock); #1;
      guard++;
    end
    check("cmd_ready", 32'(cmd_ready), 32'd1);
  endtask

  task automatic run_txn(input bit wr, input logic [22:0] adr, input logic [15:0] wd,
                         input logic [15:0] rd, input int dly);
    bit ack_e;
    logic [15:0] rdata_e;
    int rsp_e, rel_e, lat_e;
    int t0, as_edge, ds_edge, rel_edge, rsp_edge, n_rsp;
    bit oe_seen;
    logic [15:0] got_rdata;
    logic got_tmo;
    int got_lat;

    model(wr, dly, rd, ack_e, rdata_e, rsp_e, rel_e, lat_e);
    wait_ready();
    cmd_valid = 1'b1; cmd_write = wr; cmd_adr = adr; cmd_wdata = wd;
    vme_reply[6:2] = 5'($urandom);
    @(posedge clock); #1;
    t0 = cyc;
    // Busy-time commands must be ignored
    cmd_valid = 1'b1; cmd_write = 1'($urandom); cmd_adr = 23'($urandom); cmd_wdata = 16'($urandom);
    as_edge = -1; ds_edge = -1; rel_edge = -1; rsp_edge = -1; n_rsp = 0; oe_seen = 1'b0;
    got_rdata = '0; got_tmo = 1'b0; got_lat = 0;
    for (int k = 0; k < 600; k++) begin
      if (vme_d_oe) oe_seen = 1'b1;
      if (as_edge < 0 && _vme_cmd[0] == 1'b0) as_edge = cyc;
      if (ds_edge < 0 && _vme_cmd[1] == 1'b0) begin
        ds_edge = cyc;
        check("strobe_a", 32'(vme_a), 32'(adr));
        check("strobe_am", 32'(vme_am), 32'(AM));
        check("strobe_cmd", 32'(_vme_cmd), 32'({5'h1F, 1'b1, ~wr, 1'b1, 3'b000}));
        check("strobe_oe", 32'(vme_d_oe), 32'(wr));
        check("strobe_dout", 32'(vme_d_out), wr ? 32'(wd) : 32'd0);
      end
      if (ds_edge >= 0 && rel_edge < 0 && _vme_cmd[1] == 1'b1) begin
        rel_edge = cyc;
        check("release_cmd", 32'(_vme_cmd[2:0]), 32'd7);
      end
      if (rel_edge >= 0) begin
        vme_reply[1:0] = 2'b00;
        vme_d_in = 16'($urandom);
      end else if (dly >= 0 && ds_edge >= 0 && cyc - ds_edge == dly) begin
        vme_reply[1:0] = 2'b11;
        vme_d_in = rd;
      end
      if (rsp_valid) begin
        n_rsp++;
        if (rsp_edge < 0) begin
          rsp_edge = cyc; got_rdata = rsp_rdata; got_tmo = rsp_timeout;
          cmd_valid = 1'b0;
          check("resp_am", 32'(vme_am), 32'h3F);
`ifdef VME_LAT_CNT_EN
          got_lat = int'(rsp_lat);
`endif
        end
      end
      if (rsp_edge >= 0 && cyc > rsp_edge) break;
      @(posedge clock); #1;
    end
    cmd_valid = 1'b0;
    if (rsp_edge < 0) begin
      check("rsp_never_came", 32'd0, 32'd1);
    end else begin
      check("as_setup", 32'(as_edge - t0), 32'(SETUP));
      check("ds_strobe", 32'(ds_edge - as_edge), 32'(STROBE));
      check("release_time", 32'(rel_edge - ds_edge), 32'(rel_e));
      check("rsp_latency", 32'(rsp_edge - t0), 32'(rsp_e));
      check("rsp_once", 32'(n_rsp), 32'd1);
      check("rsp_timeout", 32'(got_tmo), 32'(!ack_e));
      check("rsp_rdata", 32'(got_rdata), 32'(rdata_e));
      check("oe_seen", 32'(oe_seen), 32'(wr));
`ifdef VME_LAT_CNT_EN
      check("rsp_lat", 32'(got_lat), 32'(lat_e));
`else
      check("rsp_lat_off", 32'(got_lat), 32'(lat_e - lat_e));
`endif
    end
  endtask

  task automatic reset_mid_cycle();
    int t0;
    wait_ready();
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_adr = 23'h12345; cmd_wdata = 16'hC3C3;
    vme_reply[1:0] = 2'b00;
    @(posedge clock); #1;
    t0 = cyc;
    cmd_valid = 1'b0;
    repeat (SETUP + STROBE + 5) @(posedge clock);
    #1;
    check("pre_reset_ds", 32'(_vme_cmd[1]), 32'd0);
    check("pre_reset_t", 32'(cyc - t0), 32'(SETUP + STROBE + 5));
    _reset = 1'b0;
    #1;
    check("rst_async_cmd", 32'(_vme_cmd), 32'h7FF);
    check("rst_async_oe", 32'(vme_d_oe), 32'd0);
    check("rst_async_am", 32'(vme_am), 32'h3F);
    check("rst_async_ready", 32'(cmd_ready), 32'd1);
    for (int k = 0; k < 6; k++) begin
      if (k == 2) _reset = 1'b1;
      check("rst_no_rsp", 32'(rsp_valid), 32'd0);
      @(posedge clock); #1;
    end
  endtask

  initial begin
    bit wr;
    int dly;
    _reset = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_adr = '0; cmd_wdata = '0;
    vme_d_in = '0; vme_reply = '0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_ready", 32'(cmd_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rdata", 32'(rsp_rdata), 32'd0);
    check("rst_timeout", 32'(rsp_timeout), 32'd0);
    check("rst_a", 32'(vme_a), 32'd0);
    check("rst_am", 32'(vme_am), 32'h3F);
    check("rst_cmd", 32'(_vme_cmd), 32'h7FF);
    check("rst_oe", 32'(vme_d_oe), 32'd0);
    check("rst_dout", 32'(vme_d_out), 32'd0);
    check("geo", 32'(_vme_geo), 32'(GEO));
    _reset = 1'b1;
    @(posedge clock); #1;

    run_txn(1'b1, 23'h38000, 16'hA5A5, 16'h0000, 4);
    run_txn(1'b0, 23'h38001, 16'h0000, 16'h1234, 3);
    run_txn(1'b1, 23'h00001, 16'h5A5A, 16'h0000, 0);
    run_txn(1'b0, 23'h7FFFFF, 16'h0000, 16'hDEAD, -1);
    run_txn(1'b0, 23'h2AAAAA, 16'h0000, 16'hBEEF, TIMEOUT - SYNC_DLY);
    run_txn(1'b0, 23'h155555, 16'h0000, 16'h0F0F, 10);
    reset_mid_cycle();
    run_txn(1'b0, 23'h38002, 16'h0000, 16'h4321, 1);

    for (int i = 0; i < 24; i++) begin
      wr  = 1'($urandom);
      dly = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 14));
      run_txn(wr, 23'($urandom), 16'($urandom), 16'($urandom), dly);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
